// File: rtl/ex_mem_reg.sv
// rtl/ex_mem_reg.sv - EX/MEM pipeline register with flags, operand forwarding and retire counter
module ex_mem_reg #(
    parameter int DATA_W  = 8,
    parameter int INSTR_W = 19
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               ID_EX_mem_write,
    input  logic               ID_EX_reg_write,
    input  logic               ID_EX_write_c,
    input  logic               ID_EX_write_z,
    input  logic [1:0]         ID_EX_reg_write_mux,
    input  logic [INSTR_W-1:0] ID_EX_instruction,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [DATA_W-1:0]  store_data,
    input  logic               alu_carry,
    input  logic               alu_zero,
    input  logic [2:0]         src_a_addr,
    input  logic [2:0]         src_b_addr,
    output logic               EX_MEM_valid,
    output logic               EX_MEM_mem_write,
    output logic               EX_MEM_reg_write,
    output logic [1:0]         EX_MEM_reg_write_mux,
    output logic [2:0]         EX_MEM_rd,
    output logic [DATA_W-1:0]  EX_MEM_result,
    output logic [DATA_W-1:0]  EX_MEM_store_data,
    output logic [INSTR_W-1:0] EX_MEM_instruction,
    output logic               flag_c,
    output logic               flag_z,
    output logic               fwd_a,
    output logic               fwd_b,
    output logic [15:0]        retired_count
);

    logic               valid_q, valid_d;
    logic               mem_write_q, mem_write_d;
    logic               reg_write_q, reg_write_d;
    logic [1:0]         reg_write_mux_q, reg_write_mux_d;
    logic [2:0]         rd_q, rd_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic [DATA_W-1:0]  store_data_q, store_data_d;
    logic [INSTR_W-1:0] instruction_q, instruction_d;
    logic               flag_c_q, flag_c_d;
    logic               flag_z_q, flag_z_d;
    logic [15:0]        retired_q, retired_d;

    always_comb begin
        valid_d         = valid_q;
        mem_write_d     = mem_write_q;
        reg_write_d     = reg_write_q;
        reg_write_mux_d = reg_write_mux_q;
        rd_d            = rd_q;
        result_d        = result_q;
        store_data_d    = store_data_q;
        instruction_d   = instruction_q;
        flag_c_d        = flag_c_q;
        flag_z_d        = flag_z_q;
        retired_d       = retired_q;

        // A valid instruction leaving on a flush edge still counts as retired.
        if (flush) begin
            valid_d         = 1'b0;
            mem_write_d     = 1'b0;
            reg_write_d     = 1'b0;
            reg_write_mux_d = 2'd0;
            rd_d            = 3'd0;
            result_d        = '0;
            store_data_d    = '0;
            instruction_d   = '0;
            retired_d       = retired_q + {15'd0, valid_q};
        end else if (!stall) begin
            valid_d         = 1'b1;
            mem_write_d     = ID_EX_mem_write;
            reg_write_d     = ID_EX_reg_write;
            reg_write_mux_d = ID_EX_reg_write_mux;
            rd_d            = ID_EX_instruction[13:11];
            result_d        = alu_result;
            store_data_d    = store_data;
            instruction_d   = ID_EX_instruction;
            retired_d       = retired_q + {15'd0, valid_q};
            if (ID_EX_write_c) begin
                flag_c_d = alu_carry;
            end
            if (ID_EX_write_z) begin
                flag_z_d = alu_zero;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q         <= 1'b0;
            mem_write_q     <= 1'b0;
            reg_write_q     <= 1'b0;
            reg_write_mux_q <= 2'd0;
            rd_q            <= 3'd0;
            result_q        <= '0;
            store_data_q    <= '0;
            instruction_q   <= '0;
            flag_c_q        <= 1'b0;
            flag_z_q        <= 1'b0;
            retired_q       <= 16'd0;
        end else begin
            valid_q         <= valid_d;
            mem_write_q     <= mem_write_d;
            reg_write_q     <= reg_write_d;
            reg_write_mux_q <= reg_write_mux_d;
            rd_q            <= rd_d;
            result_q        <= result_d;
            store_data_q    <= store_data_d;
            instruction_q   <= instruction_d;
            flag_c_q        <= flag_c_d;
            flag_z_q        <= flag_z_d;
            retired_q       <= retired_d;
        end
    end

    // Register 0 is hardwired, so it never needs a forwarded value.
    assign fwd_a = valid_q & reg_write_q & (rd_q == src_a_addr) & (rd_q != 3'd0);
    assign fwd_b = valid_q & reg_write_q & (rd_q == src_b_addr) & (rd_q != 3'd0);

    assign EX_MEM_valid         = valid_q;
    assign EX_MEM_mem_write     = mem_write_q;
    assign EX_MEM_reg_write     = reg_write_q;
    assign EX_MEM_reg_write_mux = reg_write_mux_q;
    assign EX_MEM_rd            = rd_q;
    assign EX_MEM_result        = result_q;
    assign EX_MEM_store_data    = store_data_q;
    assign EX_MEM_instruction   = instruction_q;
    assign flag_c               = flag_c_q;
    assign flag_z               = flag_z_q;
    assign retired_count        = retired_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb/tb_ex_mem_reg.sv - self-checking bench for ex_mem_reg
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        reset, stall, flush;
    logic        mem_write, reg_write, write_c, write_z;
    logic [1:0]  wb_mux;
    logic [18:0] instr;
    logic [7:0]  alu_result, store_data;
    logic        alu_carry, alu_zero;
    logic [2:0]  src_a, src_b;

    logic        o_valid, o_mw, o_rw, o_fc, o_fz, o_fa, o_fb;
    logic [1:0]  o_mux;
    logic [2:0]  o_rd;
    logic [7:0]  o_res, o_st;
    logic [18:0] o_instr;
    logic [15:0] o_ret;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_mem_reg #(.DATA_W(8), .INSTR_W(19)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .ID_EX_mem_write(mem_write), .ID_EX_reg_write(reg_write),
        .ID_EX_write_c(write_c), .ID_EX_write_z(write_z),
        .ID_EX_reg_write_mux(wb_mux), .ID_EX_instruction(instr),
        .alu_result(alu_result), .store_data(store_data),
        .alu_carry(alu_carry), .alu_zero(alu_zero),
        .src_a_addr(src_a), .src_b_addr(src_b),
        .EX_MEM_valid(o_valid), .EX_MEM_mem_write(o_mw), .EX_MEM_reg_write(o_rw),
        .EX_MEM_reg_write_mux(o_mux), .EX_MEM_rd(o_rd), .EX_MEM_result(o_res),
        .EX_MEM_store_data(o_st), .EX_MEM_instruction(o_instr),
        .flag_c(o_fc), .flag_z(o_fz), .fwd_a(o_fa), .fwd_b(o_fb),
        .retired_count(o_ret)
    );

    typedef struct {
        logic       rst, stl, fls, rw, wc, wz, cy, zr;
        logic [2:0] rd;
        logic [7:0] alu;
        logic [2:0] sa, sb;
        logic       e_valid, e_rw;
        logic [2:0] e_rd;
        logic [7:0] e_res;
        logic       e_fa, e_fb, e_fc, e_fz;
        logic [15:0] e_ret;
    } vec_t;

    vec_t tbl [14];

    // Reference state: the architectural contents of the stage after each edge.
    logic        m_valid, m_mw, m_rw, m_fc, m_fz;
    logic [1:0]  m_mux;
    logic [7:0]  m_res, m_st;
    logic [18:0] m_instr;
    int          m_retired;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_edge();
        if (reset) begin
            {m_valid, m_mw, m_rw, m_fc, m_fz} = '0;
            m_mux = '0; m_res = '0; m_st = '0; m_instr = '0; m_retired = 0;
        end else if (flush || !stall) begin
            if (m_valid) m_retired = (m_retired + 1) % 65536;
            if (flush) begin
                {m_valid, m_mw, m_rw} = '0;
                m_mux = '0; m_res = '0; m_st = '0; m_instr = '0;
            end else begin
                m_valid = 1'b1; m_mw = mem_write; m_rw = reg_write;
                m_mux = wb_mux; m_res = alu_result; m_st = store_data; m_instr = instr;
                if (write_c) m_fc = alu_carry;
                if (write_z) m_fz = alu_zero;
            end
        end
    endtask

    task automatic check_model();
        logic [2:0] rd;
        logic       fa, fb;
        rd = m_instr[13:11];
        fa = m_valid && m_rw && rd == src_a && rd != 0;
        fb = m_valid && m_rw && rd == src_b && rd != 0;
        chk("r_valid", 32'(o_valid), 32'(m_valid));
        chk("r_mw",    32'(o_mw),    32'(m_mw));
        chk("r_rw",    32'(o_rw),    32'(m_rw));
        chk("r_mux",   32'(o_mux),   32'(m_mux));
        chk("r_rd",    32'(o_rd),    32'(rd));
        chk("r_res",   32'(o_res),   32'(m_res));
        chk("r_st",    32'(o_st),    32'(m_st));
        chk("r_instr", 32'(o_instr), 32'(m_instr));
        chk("r_fc",    32'(o_fc),    32'(m_fc));
        chk("r_fz",    32'(o_fz),    32'(m_fz));
        chk("r_fa",    32'(o_fa),    32'(fa));
        chk("r_fb",    32'(o_fb),    32'(fb));
        chk("r_ret",   32'(o_ret),   32'(m_retired));
    endtask

    initial begin
        //          rst stl fls rw wc wz cy zr rd  alu    sa  sb  | val rw rd  res   fa fb fc fz ret
        tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 3'd0, 8'h00, 3'd0, 3'd0, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 16'd0};
        tbl[1]  = '{0, 0, 0, 1, 0, 0, 0, 0, 3'd5, 8'hA7, 3'd5, 3'd3, 1, 1, 3'd5, 8'hA7, 1, 0, 0, 0, 16'd0};
        tbl[2]  = '{0, 0, 0, 0, 1, 0, 1, 1, 3'd2, 8'h11, 3'd2, 3'd3, 1, 0, 3'd2, 8'h11, 0, 0, 1, 0, 16'd1};
        tbl[3]  = '{0, 0, 0, 1, 0, 1, 0, 1, 3'd0, 8'h22, 3'd0, 3'd0, 1, 1, 3'd0, 8'h22, 0, 0, 1, 1, 16'd2};
        tbl[4]  = '{0, 0, 0, 1, 1, 1, 0, 0, 3'd3, 8'h33, 3'd1, 3'd3, 1, 1, 3'd3, 8'h33, 0, 1, 0, 0, 16'd3};
        tbl[5]  = '{0, 1, 0, 0, 1, 1, 1, 1, 3'd7, 8'hFF, 3'd1, 3'd3, 1, 1, 3'd3, 8'h33, 0, 1, 0, 0, 16'd3};
        tbl[6]  = '{0, 1, 0, 1, 1, 0, 1, 0, 3'd6, 8'h5C, 3'd1, 3'd3, 1, 1, 3'd3, 8'h33, 0, 1, 0, 0, 16'd3};
        tbl[7]  = '{0, 1, 0, 0, 0, 1, 0, 1, 3'd1, 8'h01, 3'd1, 3'd3, 1, 1, 3'd3, 8'h33, 0, 1, 0, 0, 16'd3};
        tbl[8]  = '{0, 1, 1, 1, 1, 1, 1, 1, 3'd4, 8'h44, 3'd1, 3'd3, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 16'd4};
        tbl[9]  = '{0, 0, 1, 1, 0, 0, 0, 0, 3'd4, 8'h44, 3'd4, 3'd4, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 16'd4};
        tbl[10] = '{0, 0, 0, 1, 1, 0, 1, 0, 3'd6, 8'h5A, 3'd6, 3'd6, 1, 1, 3'd6, 8'h5A, 1, 1, 1, 0, 16'd4};
        tbl[11] = '{1, 1, 0, 1, 1, 1, 0, 0, 3'd2, 8'h99, 3'd6, 3'd6, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 16'd0};
        tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 3'd4, 8'h44, 3'd4, 3'd0, 1, 0, 3'd4, 8'h44, 0, 0, 0, 0, 16'd0};
        tbl[13] = '{1, 0, 1, 1, 1, 1, 1, 1, 3'd4, 8'h77, 3'd4, 3'd4, 0, 0, 3'd0, 8'h00, 0, 0, 0, 0, 16'd0};

        mem_write = 0; wb_mux = 2'd1; store_data = 8'h3C;
        {reset, stall, flush, reg_write, write_c, write_z, alu_carry, alu_zero} = '0;
        instr = '0; alu_result = '0; src_a = '0; src_b = '0;
        #1;

        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; stall = tbl[i].stl; flush = tbl[i].fls;
            reg_write = tbl[i].rw; write_c = tbl[i].wc; write_z = tbl[i].wz;
            alu_carry = tbl[i].cy; alu_zero = tbl[i].zr;
            instr = {5'b10101, tbl[i].rd, 11'h2B5};
            alu_result = tbl[i].alu; src_a = tbl[i].sa; src_b = tbl[i].sb;
            step();
            chk($sformatf("t%0d_valid", i), 32'(o_valid), 32'(tbl[i].e_valid));
            chk($sformatf("t%0d_rw", i),    32'(o_rw),    32'(tbl[i].e_rw));
            chk($sformatf("t%0d_rd", i),    32'(o_rd),    32'(tbl[i].e_rd));
            chk($sformatf("t%0d_res", i),   32'(o_res),   32'(tbl[i].e_res));
            chk($sformatf("t%0d_fa", i),    32'(o_fa),    32'(tbl[i].e_fa));
            chk($sformatf("t%0d_fb", i),    32'(o_fb),    32'(tbl[i].e_fb));
            chk($sformatf("t%0d_fc", i),    32'(o_fc),    32'(tbl[i].e_fc));
            chk($sformatf("t%0d_fz", i),    32'(o_fz),    32'(tbl[i].e_fz));
            chk($sformatf("t%0d_ret", i),   32'(o_ret),   32'(tbl[i].e_ret));
        end

        // Randomized traffic against the reference model.
        reset = 1; stall = 0; flush = 0;
        model_edge();
        step();
        check_model();
        for (int n = 0; n < 400; n++) begin
            reset      = ($urandom_range(0, 39) == 0);
            stall      = ($urandom_range(0, 3) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            mem_write  = 1'($urandom);
            reg_write  = 1'($urandom);
            write_c    = 1'($urandom);
            write_z    = 1'($urandom);
            alu_carry  = 1'($urandom);
            alu_zero   = 1'($urandom);
            wb_mux     = 2'($urandom);
            instr      = 19'($urandom);
            alu_result = 8'($urandom);
            store_data = 8'($urandom);
            src_a      = 3'($urandom);
            src_b      = 3'($urandom);
            model_edge();
            step();
            check_model();
        end

        // Counter wrap: 65535 loads after reset leave 0xFFFE retired.
        reset = 1; stall = 0; flush = 0;
        step();
        reset = 0;
        for (int n = 0; n < 65535; n++) step();
        chk("wrap_fffe", 32'(o_ret), 32'h0000FFFE);
        step();
        chk("wrap_ffff", 32'(o_ret), 32'h0000FFFF);
        step();
        chk("wrap_zero", 32'(o_ret), 32'h00000000);
        chk("wrap_valid", 32'(o_valid), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
